trdb_branch_map: RTL and testbench

- Collects the taken/not-taken outcome of each retired conditional branch into a fixed-length branch map.
- Hands completed or flushed maps to the trace packet emitter over a valid/ready handshake.
- Sits directly downstream of the instruction-sample capture point. It consumes the per-cycle branch retirement qualified from the core's instruction interface (ivalid, exception, interrupt).

---
 rtl/trdb_branch_map.sv | 146 ++++++++++++++
 tb/tb_trdb_branch_map.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_branch_map.sv
`default_nettype none
// ============================================================================
// Module   : trdb_branch_map
// Purpose  : Packs retired conditional-branch outcomes into fixed-length maps
//            and hands them to the packet emitter over valid/ready.
// Options  : TRDB_BRANCH_MAP_STATS_EN adds branch/map statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module trdb_branch_map #(
    parameter int unsigned MAP_LEN = 31
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         valid_i,
    input  logic                         taken_i,
    input  logic                         flush_i,
    output logic                         map_valid_o,
    input  logic                         map_ready_i,
    output logic [MAP_LEN-1:0]           map_o,
    output logic [$clog2(MAP_LEN+1)-1:0] branches_o,
    output logic                         overflow_o
`ifdef TRDB_BRANCH_MAP_STATS_EN
    ,
    output logic [31:0]                  stat_branches_o,
    output logic [31:0]                  stat_maps_o
`endif
);

    localparam int unsigned c_CNT_W = $clog2(MAP_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(MAP_LEN);

    logic [MAP_LEN-1:0] r_acc_map;
    logic [c_CNT_W-1:0] r_acc_cnt;
    logic               r_pend;
    logic [MAP_LEN-1:0] r_map;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_valid;
    logic               r_ovf;

    logic               w_full;
    logic               w_free;
    logic               w_ins;
    logic               w_carry;
    logic               w_drop;
    logic               w_flush_req;
    logic               w_trig;
    logic               w_handoff;
    logic [MAP_LEN-1:0] w_post_map;
    logic [c_CNT_W-1:0] w_post_cnt;
    logic [MAP_LEN-1:0] w_new_bit;

    assign w_full      = (r_acc_cnt == c_FULL_CNT);
    assign w_free      = !r_valid || map_ready_i;
    assign w_ins       = valid_i && !w_full;
    // A branch arriving while a full map is leaving starts the next map.
    assign w_carry     = valid_i && w_full && w_free;
    assign w_drop      = valid_i && w_full && !w_free;
    assign w_flush_req = flush_i || r_pend;

    assign w_new_bit   = MAP_LEN'(!taken_i);
    assign w_post_map  = w_ins ? (r_acc_map | (w_new_bit << r_acc_cnt)) : r_acc_map;
    assign w_post_cnt  = r_acc_cnt + c_CNT_W'(w_ins);

    assign w_trig      = (w_post_cnt == c_FULL_CNT) ||
                         (w_flush_req && (w_post_cnt != '0));
    assign w_handoff   = w_trig && w_free;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc_map <= '0;
            r_acc_cnt <= '0;
            r_pend    <= 1'b0;
            r_map     <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (clear_i) begin
            r_acc_map <= '0;
            r_acc_cnt <= '0;
            r_pend    <= 1'b0;
            r_map     <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_handoff) begin
                r_map   <= w_post_map;
                r_cnt   <= w_post_cnt;
                r_valid <= 1'b1;
                if (w_carry) begin
                    // The carried branch logically precedes any flush seen now.
                    r_acc_map <= w_new_bit;
                    r_acc_cnt <= c_CNT_W'(1);
                    r_pend    <= w_flush_req;
                end else begin
                    r_acc_map <= '0;
                    r_acc_cnt <= '0;
                    r_pend    <= 1'b0;
                end
            end else begin
                if (r_valid && map_ready_i) begin
                    r_valid <= 1'b0;
                end
                r_acc_map <= w_post_map;
                r_acc_cnt <= w_post_cnt;
                r_pend    <= w_flush_req && (w_post_cnt != '0);
            end
        end
    end

    assign map_valid_o = r_valid;
    assign map_o       = r_map;
    assign branches_o  = r_cnt;
    assign overflow_o  = r_ovf;

`ifdef TRDB_BRANCH_MAP_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_maps;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stat_branches <= '0;
            r_stat_maps     <= '0;
        end else if (clear_i) begin
            r_stat_branches <= '0;
            r_stat_maps     <= '0;
        end else begin
            if (w_ins || w_carry) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (r_valid && map_ready_i) begin
                r_stat_maps <= r_stat_maps + 32'd1;
            end
        end
    end

    assign stat_branches_o = r_stat_branches;
    assign stat_maps_o     = r_stat_maps;
`endif

endmodule
`default_nettype wire

// File: tb/tb_trdb_branch_map.sv
`default_nettype none
// ============================================================================
// Module   : tb_trdb_branch_map
// Purpose  : Self-checking bench: directed vector table, corner sequences and
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trdb_branch_map;

    localparam int L = 31;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear, valid, taken, flush, ready;
    logic         mvalid;
    logic [L-1:0] map;
    logic [4:0]   cnt;
    logic         ovf;
`ifdef TRDB_BRANCH_MAP_STATS_EN
    logic [31:0]  stat_br, stat_maps;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    trdb_branch_map #(.MAP_LEN(L)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .valid_i     (valid),
        .taken_i     (taken),
        .flush_i     (flush),
        .map_valid_o (mvalid),
        .map_ready_i (ready),
        .map_o       (map),
        .branches_o  (cnt),
        .overflow_o  (ovf)
`ifdef TRDB_BRANCH_MAP_STATS_EN
        ,
        .stat_branches_o (stat_br),
        .stat_maps_o     (stat_maps)
`endif
    );

    typedef struct {
        logic        v, t, f, r;
        logic        ev;
        logic [31:0] emap;
        logic [31:0] ecnt;
    } vec_t;
    vec_t tbl[$];

    // Reference model: accumulator as a queue of map bits, oldest first.
    bit mq[$];
    bit m_pend, m_v, m_ovf;
    int m_map, m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic t, input logic f, input logic r, input logic c);
        valid = v; taken = t; flush = f; ready = r; clear = c;
    endtask

    function automatic void add(input logic v, input logic t, input logic f, input logic ev,
                                input logic [31:0] emap, input logic [31:0] ecnt);
        vec_t e;
        e.v = v; e.t = t; e.f = f; e.r = 1'b1; e.ev = ev; e.emap = emap; e.ecnt = ecnt;
        tbl.push_back(e);
    endfunction

    function automatic int pack_q();
        int r = 0;
        foreach (mq[i]) if (mq[i]) r |= (1 << i);
        return r;
    endfunction

    task automatic model_step(input bit v, input bit t, input bit f, input bit r, input bit c);
        bit free, carry, req;
        if (c) begin
            mq.delete(); m_pend = 0; m_v = 0; m_ovf = 0; m_map = 0; m_cnt = 0;
            return;
        end
        free  = !m_v || r;
        carry = 0;
        if (v) begin
            if (mq.size() < L) mq.push_back(!t);
            else if (free)     carry = 1;
            else               m_ovf = 1;
        end
        req = f || m_pend;
        if ((mq.size() == L || (req && mq.size() > 0)) && free) begin
            m_map = pack_q(); m_cnt = mq.size(); m_v = 1;
            mq.delete(); m_pend = 0;
            if (carry) begin
                mq.push_back(!t);
                m_pend = req;
            end
        end else begin
            if (m_v && r) m_v = 0;
            m_pend = req && (mq.size() > 0);
        end
    endtask

    // Drives 31 not-taken branches, then idles; exactly one full map must appear.
    task automatic run31(input string name);
        int pulses = 0;
        int at     = -1;
        logic [31:0] got = 0;
        for (int i = 0; i < 34; i++) begin
            drive(i < 31, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
            if (mvalid) begin
                pulses++;
                if (at < 0) begin at = i; got = 32'(map); end
            end
        end
        chk({name, "_pulses"}, pulses, 1);
        chk({name, "_cycle"}, at, 30);
        chk({name, "_map"}, got, 32'h7FFF_FFFF);
    endtask

    initial begin
        drive(0, 0, 0, 1, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", mvalid, 0);
        chk("rst_map", map, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 31; i++)
            add(1, (i % 2) == 0, 0, i == 30, 32'h2AAA_AAAA, 31);
        add(1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 5, 3);
        add(0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0);
        add(1, 0, 1, 1, 4, 3);
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].t, tbl[i].f, tbl[i].r, 1'b0);
            tick();
            chk($sformatf("tbl%0d_valid", i), mvalid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_map", i), map, tbl[i].emap);
                chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].ecnt);
            end
            chk($sformatf("tbl%0d_ovf", i), ovf, 0);
        end

        // Backpressure and overflow
        drive(0, 0, 0, 0, 1); tick();
        for (int i = 0; i < 62; i++) begin
            drive(1, 0, 0, 0, 0);
            tick();
            chk("bp_valid", mvalid, i >= 30);
            if (i >= 30) begin
                chk("bp_map", map, 32'h7FFF_FFFF);
                chk("bp_cnt", cnt, 31);
            end
            chk("bp_ovf", ovf, 0);
        end
        drive(1, 0, 0, 0, 0); tick();
        chk("ovf_set", ovf, 1);
        chk("ovf_valid", mvalid, 1);
        drive(0, 0, 0, 1, 0); tick();
        chk("bp2_valid", mvalid, 1);
        chk("bp2_map", map, 32'h7FFF_FFFF);
        chk("bp2_cnt", cnt, 31);
        chk("bp2_ovf", ovf, 1);
        tick();
        chk("bp3_valid", mvalid, 0);
        chk("bp3_ovf", ovf, 1);

        // Asynchronous reset mid-map
        for (int i = 0; i < 10; i++) begin drive(1, 1, 0, 1, 0); tick(); end
        drive(0, 0, 0, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", mvalid, 0);
        chk("arst_map", map, 0);
        chk("arst_cnt", cnt, 0);
        chk("arst_ovf", ovf, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run31("after_rst");

        // Synchronous clear mid-map, with a branch in the clear cycle
        for (int i = 0; i < 10; i++) begin drive(1, 1, 0, 1, 0); tick(); end
        drive(1, 1, 1, 1, 1); tick();
        chk("clr_valid", mvalid, 0);
        chk("clr_ovf", ovf, 0);
        run31("after_clr");

`ifdef TRDB_BRANCH_MAP_STATS_EN
        drive(0, 0, 0, 1, 1); tick();
        for (int i = 0; i < 31; i++) begin drive(1, (i % 2) == 0, 0, 1, 0); tick(); end
        drive(0, 0, 0, 1, 0); tick();
        chk("stat_branches", stat_br, 31);
        chk("stat_maps", stat_maps, 1);
`endif

        // Randomized traffic against the reference model
        drive(0, 0, 0, 1, 1);
        model_step(0, 0, 0, 1, 1);
        tick();
        for (int n = 0; n < 3000; n++) begin
            logic v, t, f, r, c;
            v = ($urandom_range(0, 9) < 6);
            t = $urandom_range(0, 1);
            f = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 9) < ((n / 500) % 2 == 0 ? 7 : 2));
            c = ($urandom_range(0, 299) == 0);
            drive(v, t, f, r, c);
            model_step(v, t, f, r, c);
            tick();
            chk("rnd_valid", mvalid, m_v);
            chk("rnd_ovf", ovf, m_ovf);
            if (m_v) begin
                chk("rnd_map", map, m_map);
                chk("rnd_cnt", cnt, m_cnt);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
